// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the encryption core.
// Contents:
//   NR          number of AES-128 rounds
//   RCON        round constant table, indexed by round 0..9
//   word_t      32-bit key word
//   key_word    selects word i (0..3) of a 128-bit key, w0 at [127:96]
//   rot_word    RotWord byte rotation
//   sbox_fn     forward S-box lookup; the same table feeds the core's ROMs
package aes_pkg;

   localparam int NR = 10;

   typedef logic [31:0] word_t;

   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Entry 0 sits in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic word_t key_word(input logic [127:0] k, input int unsigned i);
      return k[127 - 32*i -: 32];
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] sbox_fn(input logic [7:0] a);
      return SBOX_TABLE[2047 - 8*int'(a) -: 8];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// 256x8 AES forward S-box as a synchronous-read ROM, one cycle of latency.
// Ports:
//   clk   rising-edge clock
//   addr  byte to substitute
//   data  S-box(addr) registered on the edge after addr is presented
module aes_sbox
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   output logic [7:0] data
);

   logic [7:0] data_d;
   logic [7:0] data_q;

   always_comb begin
      data_d = sbox_fn(addr);
   end

   // NOTE: the read register has no reset so the table can map onto block RAM;
   // its contents are only consumed after a full read cycle anyway.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/aes_128_key_sched.sv
// On-the-fly AES-128 round-key responder.
// Ports:
//   clk        rising-edge clock
//   kill_n     asynchronous active-low reset
//   key_in     cipher key, byte 0 at [127:120]
//   key_load   one-cycle strobe capturing key_in; rewinds to round 0
//   key_ready  core consumed key_round this cycle, advance to the next key
//   key_round  current round key
//   round_idx  index of the key on key_round (0..NR)
//   key_busy   next key is being computed (SUB and MIX)
//   key_err    sticky: a request arrived while not READY
module aes_128_key_sched
   import aes_pkg::*;
#(
   parameter int NR_P = NR
) (
   input  logic         clk,
   input  logic         kill_n,
   input  logic [127:0] key_in,
   input  logic         key_load,
   input  logic         key_ready,
   output logic [127:0] key_round,
   output logic [3:0]   round_idx,
   output logic         key_busy,
   output logic         key_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_SUB   = 2'd2;
   localparam logic [1:0] ST_MIX   = 2'd3;

   localparam logic [3:0] LAST_IDX = 4'(NR_P);

   logic [1:0]   state_q,  state_d;
   logic [127:0] cipher_q, cipher_d;
   logic [127:0] key_q,    key_d;
   logic [3:0]   idx_q,    idx_d;
   logic         busy_q,   busy_d;
   logic         err_q,    err_d;

   word_t rot_w;
   word_t sub_rot;
   word_t w0_n, w1_n, w2_n, w3_n;

   // key_q is stable through SUB, so the ROMs can read it unconditionally;
   // their outputs are valid in MIX.
   assign rot_w = rot_word(key_word(key_q, 3));

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .clk  (clk),
         .addr (rot_w[31 - 8*b -: 8]),
         .data (sub_rot[31 - 8*b -: 8])
      );
   end

   // XOR cascade producing the next round key.
   always_comb begin
      w0_n = key_word(key_q, 0) ^ sub_rot ^ {RCON[idx_q], 24'h0};
      w1_n = key_word(key_q, 1) ^ w0_n;
      w2_n = key_word(key_q, 2) ^ w1_n;
      w3_n = key_word(key_q, 3) ^ w2_n;
   end

   // NOTE: every next-state signal starts as a hold of its flop so no path
   // leaves one unassigned and no latch is inferred; combinational blocks
   // use blocking assignments.
   always_comb begin
      state_d  = state_q;
      cipher_d = cipher_q;
      key_d    = key_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      err_d    = err_q;

      if (key_load) begin
         // Load wins over a same-cycle request and aborts any computation.
         cipher_d = key_in;
         key_d    = key_in;
         idx_d    = '0;
         state_d  = ST_READY;
         busy_d   = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            ST_READY: begin
               if (key_ready) begin
                  if (idx_q == LAST_IDX) begin
                     key_d = cipher_q;
                     idx_d = '0;
                  end else begin
                     state_d = ST_SUB;
                     busy_d  = 1'b1;
                  end
               end
            end
            ST_SUB: begin
               state_d = ST_MIX;
               if (key_ready) err_d = 1'b1;
            end
            ST_MIX: begin
               key_d   = {w0_n, w1_n, w2_n, w3_n};
               idx_d   = idx_q + 4'd1;
               state_d = ST_READY;
               busy_d  = 1'b0;
               if (key_ready) err_d = 1'b1;
            end
            default: begin
               if (key_ready) err_d = 1'b1;
            end
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         state_q  <= ST_IDLE;
         cipher_q <= '0;
         key_q    <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cipher_q <= cipher_d;
         key_q    <= key_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign key_round = key_q;
   assign round_idx = idx_q;
   assign key_busy  = busy_q;
   assign key_err   = err_q;

endmodule
